mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller between EX/MEM pipeline register and MEM/WB pipeline register.
- Turns the EX/MEM memory controls into a single request to the multi-cycle data memory (cache system with done handshake).
- Stalls the front of the pipeline while the access is outstanding and inserts bubbles into MEM/WB.
- Presents load data and an access-error flag to MEM/WB.

Parameters:
DATA_W, 16, data and address width
TIMEOUT, 64, max WAIT cycles before access is aborted with error
CNT_W, 7, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
valid  in  1  EX/MEM holds a live instruction
Mem_en  in  1  memory enable from EX/MEM
Mem_read  in  1  load request
Mem_write  in  1  store request
address  in  DATA_W  byte address (ALU result)
write_data  in  DATA_W  store data
mem_rdata  in  DATA_W  data memory read data
mem_done  in  1  data memory access complete, one-cycle pulse
mem_addr  out  DATA_W  data memory address
mem_wdata  out  DATA_W  data memory write data
mem_rd  out  1  read strobe, one-cycle pulse
mem_wr  out  1  write strobe, one-cycle pulse
data_read  out  DATA_W  load result toward MEM/WB
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
bubble  out  1  MEM/WB must capture zeroed controls this cycle
err  out  1  unaligned or timed-out access, one cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, data register=0. All outputs 0 while reset is asserted and in the first cycle after it. Any outstanding memory access is abandoned; a late mem_done is ignored in IDLE.
- Memory op (memop) = valid & Mem_en & (Mem_read | Mem_write). Mem_read and Mem_write both set is treated as a write.
- Unaligned = memop & address[0].
- IDLE:
  - No memop: stall=0, bubble=0, data_read=0. Pass-through, no request.
  - Unaligned: err=1 for one cycle, no request, stall=0, bubble=1. Instruction retires as a nop. Stay IDLE.
  - Aligned memop:
    - Combinationally pulse mem_rd or mem_wr; mem_addr=address, mem_wdata=write_data.
    - stall=1, bubble=1; counter<=0; go WAIT.
    - Request is issued in the same cycle the op appears.
- WAIT:
  - stall=1, bubble=1, mem_rd=mem_wr=0.
  - mem_addr/mem_wdata are held from registered copies captured at issue.
  - counter increments each cycle.
  - mem_done=1: capture mem_rdata (loads; stores capture 0) and go DONE.
  - counter==TIMEOUT-1 without mem_done: go DONE with data 0 and an err pending. mem_done in the same cycle wins (no error).
- DONE:
  - stall=0, bubble=0, data_read=captured data; err=1 only if timeout pending.
  - EX/MEM advances at this edge; go IDLE.
  - Next instruction is evaluated in IDLE the following cycle, so the completed op is never re-issued.
- Latency: load with N-cycle memory (done N cycles after strobe) stalls N+1 cycles, data valid in DONE. Zero-wait memory (done same cycle as strobe) is not supported: done is sampled only in WAIT.
- mem_done in IDLE or DONE: ignored.
- Outputs are combinational from state and registers. No combinational path from mem_done to stall.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'b00, WAIT=2'b01, DONE=2'b10 (2'b11 illegal, recovers to IDLE)
  - memory-op command constants
- One sub-module, mem_wait_counter: CNT_W up-counter with clear, enable and terminal-count output (TIMEOUT-1).
- All flops use the team's async active-low dff variant.

Test Plan:
- Reset mid-WAIT: load to 0x0010 issued, rst=0 two cycles later -> stall/bubble/mem_rd drop to 0 immediately. Subsequent mem_done ignored. State IDLE.
- Aligned load: address=0x0024, Mem_read=1, memory returns 0xBEEF with done 3 cycles after strobe -> mem_rd pulses once, stall=1 for 4 cycles, DONE cycle data_read=0xBEEF, err=0.
- Store: address=0x0100, write_data=0x1234, done after 1 cycle -> mem_wr single pulse, mem_addr/mem_wdata stable 0x0100/0x1234 through WAIT, data_read=0 in DONE.
- Unaligned: address=0x0013, Mem_read=1 -> err=1 one cycle, bubble=1, stall=0, no mem_rd/mem_wr.
- Timeout: load, mem_done never asserted -> stall high exactly TIMEOUT+1 cycles, then DONE with data_read=0 and err=1. Also cover done arriving at count TIMEOUT-1 -> err=0.
- Back-to-back: load then store, each done after 2 cycles -> exactly one strobe per op. Second strobe appears the cycle after first DONE. No duplicate issue.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_pkg
// Description : Shared state encoding, memory command type and command decode
//               for the memory-stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    // Controller state encoding; 2'b11 is illegal and recovers to ST_IDLE
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Memory command presented by the EX/MEM register
    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } mem_cmd_e;

    // Read and write both set resolves to a write
    function automatic mem_cmd_e decode_cmd(
        input logic valid,
        input logic mem_en,
        input logic mem_read,
        input logic mem_write
    );
        if (!(valid && mem_en)) return CMD_NONE;
        if (mem_write)          return CMD_WRITE;
        if (mem_read)           return CMD_READ;
        return CMD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Up-counter with synchronous clear, count enable and a
//               terminal-count flag at TIMEOUT-1, used to bound memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] C_TC_VALUE = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Clear wins over enable so a fresh issue always starts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_tc = (r_count == C_TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage controller. Issues one strobe per memory op to a
//               multi-cycle data memory, stalls the front end and bubbles
//               MEM/WB while the access is outstanding, and returns load data
//               plus an error flag for unaligned or timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              Mem_en,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] data_read,
    output logic              stall,
    output logic              bubble,
    output logic              err
);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_live;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data;
    logic              r_is_write;
    logic              r_timeout_err;

    mem_cmd_e          w_cmd;
    logic              w_memop;
    logic              w_unaligned;
    logic              w_issue;
    logic              w_in_wait;
    logic              w_tc;

    // Ops are ignored until the first clock after reset has passed
    assign w_cmd       = decode_cmd(valid, Mem_en, Mem_read, Mem_write);
    assign w_memop     = r_live && (w_cmd != CMD_NONE);
    assign w_unaligned = w_memop && address[0];
    assign w_issue     = (r_state == ST_IDLE) && w_memop && !address[0];
    assign w_in_wait   = (r_state == ST_WAIT);

    mem_wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_issue),
        .i_en  (w_in_wait),
        .o_tc  (w_tc)
    );

    // Live flag holds all outputs quiet during the first cycle after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: done beats timeout in the same WAIT cycle
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next_state = w_issue ? ST_WAIT : ST_IDLE;
            ST_WAIT: w_next_state = (mem_done || w_tc) ? ST_DONE : ST_WAIT;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request copies captured at issue, result and timeout flag captured in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_is_write    <= 1'b0;
            r_data        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_addr     <= address;
                r_wdata    <= write_data;
                r_is_write <= (w_cmd == CMD_WRITE);
            end
            if (w_in_wait) begin
                if (mem_done) begin
                    r_data        <= r_is_write ? '0 : mem_rdata;
                    r_timeout_err <= 1'b0;
                end else if (w_tc) begin
                    r_data        <= '0;
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    // Outputs depend only on state and registers, never on mem_done
    always_comb begin
        stall     = 1'b0;
        bubble    = 1'b0;
        err       = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        data_read = '0;
        if (r_live) begin
            case (r_state)
                ST_IDLE: begin
                    mem_addr  = address;
                    mem_wdata = write_data;
                    if (w_unaligned) begin
                        err    = 1'b1;
                        bubble = 1'b1;
                    end else if (w_issue) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        mem_rd = (w_cmd == CMD_READ);
                        mem_wr = (w_cmd == CMD_WRITE);
                    end
                end
                ST_WAIT: begin
                    stall     = 1'b1;
                    bubble    = 1'b1;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                end
                ST_DONE: begin
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                    data_read = r_data;
                    err       = r_timeout_err;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. A transaction-level
//               model predicts the per-cycle stall/bubble/strobe/data/err
//               timeline of each op from its type, alignment and memory delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              valid      = 1'b0;
    logic              Mem_en     = 1'b0;
    logic              Mem_read   = 1'b0;
    logic              Mem_write  = 1'b0;
    logic              mem_done   = 1'b0;
    logic [DATA_W-1:0] address    = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic [DATA_W-1:0] mem_rdata  = '0;

    wire  [DATA_W-1:0] mem_addr;
    wire  [DATA_W-1:0] mem_wdata;
    wire               mem_rd;
    wire               mem_wr;
    wire  [DATA_W-1:0] data_read;
    wire               stall;
    wire               bubble;
    wire               err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .Mem_en     (Mem_en),
        .Mem_read   (Mem_read),
        .Mem_write  (Mem_write),
        .address    (address),
        .write_data (write_data),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .data_read  (data_read),
        .stall      (stall),
        .bubble     (bubble),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All control outputs and load data quiet
    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},  32'(stall),  32'h0);
        chk({tag, "_bubble"}, 32'(bubble), 32'h0);
        chk({tag, "_err"},    32'(err),    32'h0);
        chk({tag, "_strobe"}, 32'({mem_rd, mem_wr}), 32'h0);
        chk({tag, "_data"},   32'(data_read), 32'h0);
    endtask

    task automatic idle_inputs();
        valid     = 1'b0;
        Mem_en    = 1'b0;
        Mem_read  = 1'b0;
        Mem_write = 1'b0;
        mem_done  = 1'b0;
    endtask

    // One cycle with no memory op; a stray mem_done must be ignored
    task automatic idle_cycle();
        int mode;
        mode       = int'($urandom_range(0, 2));
        valid      = (mode == 0) ? 1'b0 : 1'b1;
        Mem_en     = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        Mem_read   = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        Mem_write  = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        address    = 16'($urandom);
        write_data = 16'($urandom);
        mem_done   = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_quiet("idle");
        chk("idle_addr", 32'(mem_addr), 32'(address));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Present one op at posedge+1 in IDLE; the memory pulses done dly cycles
    // after the strobe (dly > TIMEOUT means it never answers).
    task automatic run_op(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] rd, input int dly);
        int  wait_len;
        bit  timed_out;
        valid      = 1'b1;
        Mem_en     = 1'b1;
        Mem_write  = wr;
        Mem_read   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        address    = a;
        write_data = wd;
        mem_done   = 1'b0;
        @(negedge clk);
        if (a[0]) begin
            chk("unal_err",    32'(err),    32'h1);
            chk("unal_bubble", 32'(bubble), 32'h1);
            chk("unal_stall",  32'(stall),  32'h0);
            chk("unal_strobe", 32'({mem_rd, mem_wr}), 32'h0);
            @(posedge clk); #1;
            idle_inputs();
            return;
        end
        chk("iss_rd",     32'(mem_rd),    32'(!wr));
        chk("iss_wr",     32'(mem_wr),    32'(wr));
        chk("iss_stall",  32'(stall),     32'h1);
        chk("iss_bubble", 32'(bubble),    32'h1);
        chk("iss_err",    32'(err),       32'h0);
        chk("iss_addr",   32'(mem_addr),  32'(a));
        chk("iss_wdata",  32'(mem_wdata), 32'(wd));
        timed_out = (dly > TIMEOUT);
        wait_len  = timed_out ? TIMEOUT : dly;
        for (int k = 1; k <= wait_len; k++) begin
            @(posedge clk); #1;
            address    = 16'($urandom);
            write_data = 16'($urandom);
            mem_done   = (k == dly);
            mem_rdata  = (k == dly) ? rd : 16'($urandom);
            @(negedge clk);
            chk("wait_stall",  32'(stall),     32'h1);
            chk("wait_bubble", 32'(bubble),    32'h1);
            chk("wait_strobe", 32'({mem_rd, mem_wr}), 32'h0);
            chk("wait_err",    32'(err),       32'h0);
            chk("wait_addr",   32'(mem_addr),  32'(a));
            chk("wait_wdata",  32'(mem_wdata), 32'(wd));
        end
        @(posedge clk); #1;
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        @(negedge clk);
        chk("done_stall",  32'(stall),  32'h0);
        chk("done_bubble", 32'(bubble), 32'h0);
        chk("done_strobe", 32'({mem_rd, mem_wr}), 32'h0);
        chk("done_data",   32'(data_read), (wr || timed_out) ? 32'h0 : 32'(rd));
        chk("done_err",    32'(err),    32'(timed_out));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        // Reset held with a live load on the inputs: everything stays quiet
        rst      = 1'b0;
        valid    = 1'b1;
        Mem_en   = 1'b1;
        Mem_read = 1'b1;
        address  = 16'h0024;
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_addr", 32'(mem_addr), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");
        chk("post_rst_addr", 32'(mem_addr), 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        idle_cycle();

        // Reset mid-WAIT: load to 0x0010, rst asserted two cycles after issue
        valid    = 1'b1;
        Mem_en   = 1'b1;
        Mem_read = 1'b1;
        address  = 16'h0010;
        @(negedge clk);
        chk("mw_issue_rd", 32'(mem_rd), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mw_stall",  32'(stall),  32'h0);
        chk("mw_bubble", 32'(bubble), 32'h0);
        chk("mw_rd",     32'(mem_rd), 32'h0);
        idle_inputs();
        @(posedge clk); #1;
        rst      = 1'b1;
        mem_done = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk_quiet("mw_late1");
        @(posedge clk); #1;
        mem_done = 1'b1;
        @(negedge clk);
        chk_quiet("mw_late2");
        @(posedge clk); #1;
        idle_inputs();

        // Directed ops
        run_op(1'b0, 16'h0024, 16'h0000, 16'hBEEF, 3);
        idle_cycle();
        run_op(1'b1, 16'h0100, 16'h1234, 16'h5555, 1);
        idle_cycle();
        run_op(1'b0, 16'h0013, 16'h0000, 16'h0000, 1);
        idle_cycle();
        run_op(1'b0, 16'h0040, 16'h0000, 16'h7777, TIMEOUT + 10);
        idle_cycle();
        run_op(1'b0, 16'h0042, 16'h0000, 16'hA5A5, TIMEOUT);
        idle_cycle();

        // Back-to-back: second op issues the cycle after the first DONE
        run_op(1'b0, 16'h0200, 16'h0000, 16'h1111, 2);
        run_op(1'b1, 16'h0202, 16'h2222, 16'h3333, 2);
        idle_cycle();

        // Randomized ops with random gaps
        for (int n = 0; n < 30; n++) begin
            int gap;
            int dly;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
            dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 6));
            run_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom), dly);
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
